// File: rtl/term_sum_accumulator.sv
// Packet accumulator: sums a valid/ready stream of unsigned terms and emits sum, count and status per packet.
// Build option TERM_SUM_SATURATE_EN: clamp the sum at 2^WIDTH-1 on carry-out instead of wrapping.
module term_sum_accumulator #(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned WIDTH     = 5,
   parameter int unsigned MAX_TERMS = 8,
   parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_sum,
   output logic [CNT_W-1:0]    out_count,
   output logic                out_ovf,
   output logic                out_trunc
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] L_MAX_TERMS = CNT_W'(MAX_TERMS);

   state_t             r_state;
   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_sum;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_out_ovf;
   logic               r_out_trunc;

   logic               w_accept;
   logic [WIDTH:0]     w_term_ext;
   logic [WIDTH:0]     w_add;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_ovf_nxt;
   logic               w_at_limit;
   logic               w_done;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_term_ext = {{(WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
   assign w_add      = {1'b0, r_acc} + w_term_ext;

   // Anything other than ACCUM (IDLE, or HOLD being drained) starts a fresh packet.
   always_comb begin
      w_acc_nxt = w_term_ext[WIDTH-1:0];
      w_cnt_nxt = CNT_W'(1);
      w_ovf_nxt = 1'b0;
      if (r_state == S_ACCUM) begin
         w_ovf_nxt = r_ovf | w_add[WIDTH];
         w_cnt_nxt = r_count + CNT_W'(1);
`ifdef TERM_SUM_SATURATE_EN
         w_acc_nxt = w_ovf_nxt ? '1 : w_add[WIDTH-1:0];
`else
         w_acc_nxt = w_add[WIDTH-1:0];
`endif
      end
   end

   assign w_at_limit = (w_cnt_nxt == L_MAX_TERMS);
   assign w_done     = in_last || w_at_limit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_count     <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_count <= '0;
         r_out_ovf   <= 1'b0;
         r_out_trunc <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= w_acc_nxt;
         r_count <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
         if (w_done) begin
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_nxt;
            r_out_count <= w_cnt_nxt;
            r_out_ovf   <= w_ovf_nxt;
            r_out_trunc <= w_at_limit && !in_last;
         end else begin
            r_state     <= S_ACCUM;
            r_out_valid <= 1'b0;
         end
      end else if (r_state == S_HOLD && out_ready) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_count = r_out_count;
   assign out_ovf   = r_out_ovf;
   assign out_trunc = r_out_trunc;

endmodule

// File: tb/tb_term_sum_accumulator.sv
// Bench for term_sum_accumulator: table-driven packets checked through a result scoreboard, plus handshake corner cases.
module tb_term_sum_accumulator;

   localparam int unsigned IN_WIDTH  = 4;
   localparam int unsigned WIDTH     = 5;
   localparam int unsigned MAX_TERMS = 8;
   localparam int unsigned CNT_W     = 4;
`ifdef TERM_SUM_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
      logic             trunc;
   } res_t;

   typedef struct {
      logic [IN_WIDTH-1:0] data;
      logic                last;
      logic                chk;
      logic [WIDTH-1:0]    sum;
      logic [CNT_W-1:0]    cnt;
      logic                ovf;
      logic                trunc;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [IN_WIDTH-1:0] in_data;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_sum;
   logic [CNT_W-1:0]    out_count;
   logic                out_ovf;
   logic                out_trunc;

   int   n_checks = 0;
   int   n_errors = 0;
   res_t sb[$];
   vec_t vt[$];

   term_sum_accumulator #(
      .IN_WIDTH (IN_WIDTH),
      .WIDTH    (WIDTH),
      .MAX_TERMS(MAX_TERMS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sum  (out_sum),
      .out_count(out_count),
      .out_ovf  (out_ovf),
      .out_trunc(out_trunc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t vterm(input logic [IN_WIDTH-1:0] d);
      return '{d, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 1'b0};
   endfunction

   function automatic vec_t vend(input logic [IN_WIDTH-1:0] d, input logic l, input logic [WIDTH-1:0] s,
                                 input logic [CNT_W-1:0] c, input logic o, input logic t);
      return '{d, l, 1'b1, s, c, o, t};
   endfunction

   // Drive one term and wait (bounded) for it to be accepted; returns 1 time unit after the accepting edge.
   task automatic send(input logic [IN_WIDTH-1:0] d, input logic l, input logic has_exp, input res_t e);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      if (has_exp) sb.push_back(e);
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("sb_sum",   32'(out_sum),   32'(e.sum));
            check("sb_count", 32'(out_count), 32'(e.cnt));
            check("sb_ovf",   32'(out_ovf),   32'(e.ovf));
            check("sb_trunc", 32'(out_trunc), 32'(e.trunc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_t none;
      none = '{5'd0, 4'd0, 1'b0, 1'b0};

      vt.push_back(vterm(1)); vt.push_back(vterm(3));
      vt.push_back(vend(2, 1, 6, 3, 0, 0));
      vt.push_back(vterm(15)); vt.push_back(vterm(15));
      vt.push_back(vend(15, 1, SAT ? 5'd31 : 5'd13, 3, 1, 0));
      for (int i = 0; i < 7; i++) vt.push_back(vterm(1));
      vt.push_back(vend(1, 0, 8, 8, 0, 1));
      vt.push_back(vterm(1));
      vt.push_back(vend(0, 1, 1, 2, 0, 0));
      for (int i = 0; i < 7; i++) vt.push_back(vterm(2));
      vt.push_back(vend(2, 1, 16, 8, 0, 0));
      vt.push_back(vterm(15)); vt.push_back(vterm(15));
      vt.push_back(vend(1, 1, 31, 3, 0, 0));
      vt.push_back(vterm(15)); vt.push_back(vterm(15));
      vt.push_back(vend(2, 1, SAT ? 5'd31 : 5'd0, 3, 1, 0));
      vt.push_back(vterm(15)); vt.push_back(vterm(15)); vt.push_back(vterm(15));
      vt.push_back(vend(0, 1, SAT ? 5'd31 : 5'd13, 4, 1, 0));
      vt.push_back(vend(15, 1, 15, 1, 0, 0));

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_out_ovf",   32'(out_ovf),   32'd0);
      check("rst_out_trunc", 32'(out_trunc), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < vt.size(); i++)
         send(vt[i].data, vt[i].last, vt[i].chk, '{vt[i].sum, vt[i].cnt, vt[i].ovf, vt[i].trunc});
      @(posedge clk);
      #1;

      // Result held with the consumer stalled; a pending term must be ignored.
      out_ready = 1'b0;
      send(5, 0, 1'b0, none);
      send(6, 1, 1'b1, '{5'd11, 4'd2, 1'b0, 1'b0});
      in_valid = 1'b1;
      in_data  = 4'd15;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready",  32'(in_ready),  32'd0);
         check("hold_out_sum",   32'(out_sum),   32'd11);
         check("hold_out_count", 32'(out_count), 32'd2);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold_released", 32'(out_valid), 32'd0);

      // Back-to-back single-term packets: one result per cycle.
      send(7, 1, 1'b1, '{5'd7, 4'd1, 1'b0, 1'b0});
      check("b2b0_valid", 32'(out_valid), 32'd1);
      check("b2b0_sum",   32'(out_sum),   32'd7);
      send(2, 1, 1'b1, '{5'd2, 4'd1, 1'b0, 1'b0});
      check("b2b1_valid", 32'(out_valid), 32'd1);
      check("b2b1_sum",   32'(out_sum),   32'd2);
      send(5, 1, 1'b1, '{5'd5, 4'd1, 1'b0, 1'b0});
      check("b2b2_valid", 32'(out_valid), 32'd1);
      check("b2b2_sum",   32'(out_sum),   32'd5);
      @(posedge clk);
      #1;
      check("b2b_idle", 32'(out_valid), 32'd0);

      // Reset in the middle of an open packet discards it.
      send(3, 0, 1'b0, none);
      send(4, 0, 1'b0, none);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0;
      send(4, 1, 1'b1, '{5'd4, 4'd1, 1'b0, 1'b0});
      check("midrst_latency_valid", 32'(out_valid), 32'd1);
      check("midrst_sum",           32'(out_sum),   32'd4);
      check("midrst_count",         32'(out_count), 32'd1);

      repeat (5) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/term_sum_accumulator.md
Name: term_sum_accumulator

Overview:
- Parametrised successor to the fixed constant-sum blocks: the operand terms are no longer hard-wired constants.
- Accepts a serial stream of unsigned terms over a valid/ready input and accumulates them into a WIDTH-bit sum.
- Delivers the sum, a term count and status flags over a valid/ready output.
- Sits between a term producer (decoder/test sequencer) and any result consumer; one result per packet delimited by in_last.

Parameters:
- IN_WIDTH, 4, width of each input term (unsigned).
- WIDTH, 5, width of the accumulated sum (WIDTH >= IN_WIDTH).
- MAX_TERMS, 8, maximum terms per packet before forced termination (>= 1).
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  term present on in_data.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  IN_WIDTH  unsigned term.
- in_last  input  1  marks final term of packet.
- out_valid  output  1  result held on out_* ports.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH  accumulated sum.
- out_count  output  CNT_W  number of terms in packet (1..MAX_TERMS).
- out_ovf  output  1  sticky: a carry out of bit WIDTH-1 occurred in this packet.
- out_trunc  output  1  packet ended by MAX_TERMS limit, not in_last.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; acc, count, out_sum, out_count, out_ovf, out_trunc all 0; out_valid=0.
- Reset mid-packet or while a result is held discards everything; there is no partial output.
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- in_ready = !out_valid || out_ready, so the first term of the next packet can be accepted in the same cycle a result is consumed.
- States:
  - IDLE: no packet in progress, out_valid=0.
  - ACCUM: packet in progress.
  - HOLD: out_valid=1, all out_* registered and stable until consumed.
- First term accepted (IDLE, or HOLD with out_ready): acc = zero-extended in_data; count=1; ovf=0.
- Subsequent term (ACCUM): acc = acc + in_data using a (WIDTH+1)-bit add.
  - Wrap mode: the low WIDTH bits are kept.
  - If the carry is set, ovf=1 (sticky).
  - count = count + 1.
- Termination: on the accepted term where in_last=1, or where count becomes MAX_TERMS, the block moves to HOLD.
  - The final acc/count/ovf are registered into out_*.
  - out_trunc = (count reached MAX_TERMS) && !in_last.
  - If in_last and the limit coincide, out_trunc=0.
- Latency: out_valid rises the cycle after the final term is accepted; a single-term packet gives out_sum = in_data one cycle later.
- HOLD, out_ready=0: in_ready=0; outputs stable; in_data is ignored.
- HOLD, out_ready=1, no input: next state IDLE, out_valid=0.
- HOLD, out_ready=1, input accepted: next state ACCUM, or HOLD again if that term has in_last=1 or MAX_TERMS=1. Back-to-back single-term packets therefore give one result per cycle.
- IDLE/ACCUM: in_valid=0 is a stall; the state is held with no timeout.
- out_* values are don't-care when out_valid=0; the bench checks them only while out_valid=1.

Optional Feature:
- Macro: TERM_SUM_SATURATE_EN.
- Defined: on carry out, acc clamps to 2^WIDTH-1 and stays clamped for the rest of the packet; out_ovf is still set.
- Not defined: modulo-2^WIDTH wrap as described above.
- Handshake, timing and count behaviour are identical in both builds.

Test Plan:
- Terms 1,3,2 (last on 2), out_ready=1 -> one cycle after the last term: out_sum=6, out_count=3, out_ovf=0, out_trunc=0.
- Terms 15,15,15 (last), WIDTH=5 -> out_sum=13, out_ovf=1 in wrap build; out_sum=31, out_ovf=1 with TERM_SUM_SATURATE_EN.
- Nine terms of 1, no in_last, MAX_TERMS=8 -> result out_sum=8, out_count=8, out_trunc=1; the ninth term starts a new packet (count=1).
- Result held, out_ready low 3 cycles -> out_valid=1, in_ready=0, out_* unchanged for all 3 cycles; consumed on the 4th cycle.
- Single-term packets 7,2,5 on consecutive cycles with out_ready=1 -> out_valid high 3 consecutive cycles with out_sum 7,2,5 and out_count=1 each.
- rst asserted after 2 terms of an open packet -> next cycle out_valid=0, state IDLE; next packet 4 (last) -> out_sum=4, out_count=1.
